// File: rtl/ow_slot_decoder.sv
// 1-Wire slave slot timing: classifies master low periods into reset / write-0 / write-1,
// answers resets with a presence pulse and holds DQ low for read-0 slots.
module ow_slot_decoder #(
    parameter int CNT_W     = 16,
    parameter int T_RST_MIN = 4800,
    parameter int T_BIT_TH  = 300,
    parameter int T_PDH     = 300,
    parameter int T_PDL     = 1200,
    parameter int T_RD_HOLD = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic dq,
    input  logic dq_rise,
    input  logic dq_fall,
    input  logic tx_en,
    input  logic tx_bit,
    output logic bit_valid,
    output logic bit_val,
    output logic reset_det,
    output logic tx_done,
    output logic dq_pull,
    output logic busy
);

    typedef enum logic [2:0] {IDLE, LOW, RD_HOLD, PRES_WAIT, PRES_DRIVE} state_t;

    // cnt is cleared on LOW entry, one cycle after the fall, so the low time is cnt+1
    // at the rise; the decode limits are shifted down by one to compensate.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(T_RST_MIN - 1);
    localparam logic [CNT_W-1:0] BIT_LIM = CNT_W'(T_BIT_TH - 1);
    localparam logic [CNT_W-1:0] PDH_END = CNT_W'(T_PDH);
    localparam logic [CNT_W-1:0] PDL_END = CNT_W'(T_PDL - 1);
    localparam logic [CNT_W-1:0] RDH_END = CNT_W'(T_RD_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             slot_rd;
    logic             fall, rise;

    // edge pulses are qualified by the settled level so a stray pulse cannot open a slot
    assign fall = dq_fall & ~dq;
    assign rise = dq_rise & dq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            slot_rd   <= 1'b0;
            bit_valid <= 1'b0;
            bit_val   <= 1'b0;
            reset_det <= 1'b0;
            tx_done   <= 1'b0;
            dq_pull   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            reset_det <= 1'b0;
            tx_done   <= 1'b0;
            cnt       <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            case (state)
                IDLE, PRES_WAIT: begin
                    if (fall) begin
                        slot_rd <= tx_en;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        dq_pull <= 1'b0;
                        state   <= (tx_en && !tx_bit) ? RD_HOLD : LOW;
                        if (tx_en && !tx_bit)
                            dq_pull <= 1'b1;
                    end else if (state == PRES_WAIT && cnt == PDH_END) begin
                        cnt     <= '0;
                        dq_pull <= 1'b1;
                        state   <= PRES_DRIVE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        cnt <= '0;
                        if (cnt >= RST_LIM) begin
                            reset_det <= 1'b1;
                            state     <= PRES_WAIT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                            if (slot_rd) begin
                                tx_done <= 1'b1;
                            end else begin
                                bit_valid <= 1'b1;
                                bit_val   <= (cnt < BIT_LIM);
                            end
                        end
                    end
                end
                RD_HOLD: begin
                    if (cnt == RDH_END) begin
                        cnt     <= '0;
                        dq_pull <= 1'b0;
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                PRES_DRIVE: begin
                    if (cnt == PDL_END) begin
                        cnt     <= '0;
                        dq_pull <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    cnt     <= '0;
                    dq_pull <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ow_slot_decoder.md
# ow_slot_decoder

Timing core of the 1-Wire slave front end in the virtual DS2431. It consumes the synchronized DQ level and the single-cycle edge pulses from the input conditioning stage. It measures each low period to classify reset pulses and master write slots (0/1), then generates the presence pulse. It also serves master read slots by holding DQ low for a transmitted 0. The ROM/memory command layer above it sees only bit-level strobes.

## Interface
- CNT_W, 16, width of the low-time/phase counter
- T_RST_MIN, 4800, min low cycles classified as reset (480 µs @ 10 MHz)
- T_BIT_TH, 300, write slot: low < T_BIT_TH cycles decodes as 1, otherwise 0
- T_PDH, 300, cycles from reset_det to presence start
- T_PDL, 1200, presence pulse length in cycles
- T_RD_HOLD, 300, cycles DQ is held low for a read-0 slot

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dq  in  1  synchronized DQ level
- dq_rise  in  1  one-cycle pulse, DQ rising edge
- dq_fall  in  1  one-cycle pulse, DQ falling edge
- tx_en  in  1  next slot is a master read slot
- tx_bit  in  1  bit to return in that read slot
- bit_valid  out  1  one-cycle strobe, write slot decoded
- bit_val  out  1  decoded bit, valid with bit_valid, held until next strobe
- reset_det  out  1  one-cycle strobe, reset pulse detected
- tx_done  out  1  one-cycle strobe, read slot finished
- dq_pull  out  1  1 = drive DQ low (open-drain enable)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOW, RD_HOLD, PRES_WAIT, PRES_DRIVE. The counter is cleared on every state entry and saturates at 2^CNT_W−1.
- IDLE:
  - dq_fall → latch tx_en/tx_bit into slot_rd/slot_bit.
  - If tx_en=1 and tx_bit=0 → RD_HOLD.
  - Otherwise → LOW.
  - dq_rise is ignored.
- LOW: counter increments each cycle. On dq_rise:
  - cnt ≥ T_RST_MIN → reset_det, go to PRES_WAIT. No bit_valid or tx_done, even if slot_rd.
  - Else if slot_rd → tx_done, go to IDLE.
  - Else → bit_valid, bit_val = (cnt < T_BIT_TH), go to IDLE.
- RD_HOLD: dq_pull=1 for T_RD_HOLD cycles, then release, pulse tx_done, go to IDLE. DQ edges are ignored. A master reset that overlaps a read-0 slot is not detected.
- PRES_WAIT: wait T_PDH cycles, then go to PRES_DRIVE. A dq_fall here abandons the presence pulse and goes to LOW (new slot, tx_en latched as in IDLE).
- PRES_DRIVE: dq_pull=1 for exactly T_PDL cycles, then go to IDLE. DQ edges are ignored, so the rise seen after release is harmless.
- DQ held low indefinitely: the counter saturates and no strobe fires until dq_rise.
- dq_fall and dq_rise in the same cycle cannot occur (upstream guarantee). If both appear, fall takes priority in IDLE and rise in LOW.
- rst: state IDLE, counter 0, all outputs 0 (bit_val 0). Reset mid-slot or mid-presence releases dq_pull on the next clock edge.

## Timing
- All outputs are registered. Strobes assert in the cycle after the triggering dq_rise or counter terminal value, for exactly 1 cycle.
- Low-time count is the number of clocks from the dq_fall cycle (inclusive) up to, but not including, the dq_rise cycle. Upstream sync latency cancels out because both edges are delayed equally.
- Presence timing:
  - dq_pull first asserts T_PDH+1 cycles after reset_det.
  - It stays high for T_PDL cycles.
- Read-0 timing:
  - dq_pull asserts the cycle after dq_fall and lasts T_RD_HOLD cycles.
  - tx_done follows on the cycle after release.
- busy is high from the cycle after dq_fall until the return to IDLE.

## Test plan
- Low of 60 cycles then rise (tx_en=0) → one bit_valid, bit_val=1; no reset_det.
- Low of 600 cycles → bit_valid, bit_val=0. Repeat at 299 and 300 → bit_val 1 and 0 respectively.
- Low of 5000 cycles → reset_det. dq_pull high starting 301 cycles later, for 1200 cycles, then busy=0. Repeat with 4799 → bit_valid (bit_val 0), no reset_det.
- tx_en=1, tx_bit=0, master low 20 cycles → dq_pull for 300 cycles, tx_done once, no bit_valid. Repeat with tx_bit=1 → no dq_pull, tx_done the cycle after rise.
- dq_fall 100 cycles into PRES_WAIT → no dq_pull. A 60-cycle low decodes as bit_val=1.
- rst asserted mid-PRES_DRIVE and mid-RD_HOLD → dq_pull=0, busy=0 the next cycle. A following 5000-cycle low still yields reset_det.
